// File: rtl/arb_rr_2a1_pkg.sv
// arb_rr_2a1 shared types: FSM state encoding,
// burst counter width and small helpers.
package arb_rr_2a1_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    OWN0 = ST_OWN0,
    OWN1 = ST_OWN1
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  // Saturating increment of the burst counter.
  function automatic cnt_t sat_inc(
    input cnt_t c,
    input cnt_t lim
  );
    return (c >= lim) ? lim : c + cnt_t'(1);
  endfunction

  // Ownership state for a source index.
  function automatic state_t own_st(
    input logic idx
  );
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/arb_rr_2a1_if.sv
// arb_rr_2a1 handshake bundle: two sources in,
// one registered output with its selector.
interface arb_rr_2a1_if #(
  parameter int W = 8
);

  logic [W-1:0] x0;
  logic         x0_v;
  logic         x0_r;
  logic [W-1:0] x1;
  logic         x1_v;
  logic         x1_r;
  logic [W-1:0] y;
  logic         y_v;
  logic         y_r;
  logic         s;

  modport slave (
    input  x0, x0_v, x1, x1_v, y_r,
    output x0_r, x1_r, y, y_v, s
  );

  modport master (
    output x0, x0_v, x1, x1_v, y_r,
    input  x0_r, x1_r, y, y_v, s
  );

endinterface

// File: rtl/arb_rr_2a1_gnt.sv
// arb_gnt_2: combinational grant for arb_rr_2a1.
// ARB_FIXPRI_EN selects fixed priority (source 0 wins).
module arb_gnt_2
  import arb_rr_2a1_pkg::*;
#(
  parameter int BURST = 4
) (
  input  state_t     i_state,
  input  cnt_t       i_cnt,
  input  logic       i_last,
  input  logic       i_x0_v,
  input  logic       i_x1_v,
  output logic [1:0] o_gnt
);

`ifdef ARB_FIXPRI_EN

  // Source 0 always wins; state, count and last ignored.
  always_comb begin
    o_gnt = 2'b00;
    if (i_x0_v) begin
      o_gnt = 2'b01;
    end else if (i_x1_v) begin
      o_gnt = 2'b10;
    end
  end

`else

  logic w_more;

  assign w_more = i_cnt < cnt_t'(BURST);

  // Round robin: owner keeps the grant until its burst
  // is used up while the other source is waiting.
  always_comb begin
    o_gnt = 2'b00;
    case (i_state)
      OWN0: begin
        if (i_x0_v && (w_more || !i_x1_v)) begin
          o_gnt = 2'b01;
        end else if (i_x1_v) begin
          o_gnt = 2'b10;
        end
      end
      OWN1: begin
        if (i_x1_v && (w_more || !i_x0_v)) begin
          o_gnt = 2'b10;
        end else if (i_x0_v) begin
          o_gnt = 2'b01;
        end
      end
      default: begin
        if (i_x0_v && i_x1_v) begin
          o_gnt = i_last ? 2'b01 : 2'b10;
        end else if (i_x0_v) begin
          o_gnt = 2'b01;
        end else if (i_x1_v) begin
          o_gnt = 2'b10;
        end
      end
    endcase
  end

`endif

endmodule

// File: rtl/arb_rr_2a1.sv
// arb_rr_2a1: two-source round-robin arbiter with burst
// limit and registered output. Option: ARB_FIXPRI_EN.
module arb_rr_2a1
  import arb_rr_2a1_pkg::*;
#(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input logic         clk,
  input logic         rst,
  arb_rr_2a1_if.slave bus
);

  state_t       r_state;
  cnt_t         r_cnt;
  logic         r_last;
  logic [W-1:0] r_y;
  logic         r_yv;
  logic         r_s;

  state_t       w_state_n;
  cnt_t         w_cnt_n;
  logic         w_last_n;
  logic [W-1:0] w_y_n;
  logic         w_yv_n;
  logic         w_s_n;

  logic         w_load;
  logic [1:0]   w_gnt;
  logic         w_gidx;
  logic         w_take;
  logic [W-1:0] w_gdat;

  arb_gnt_2 #(
    .BURST (BURST)
  ) u_gnt (
    .i_state (r_state),
    .i_cnt   (r_cnt),
    .i_last  (r_last),
    .i_x0_v  (bus.x0_v),
    .i_x1_v  (bus.x1_v),
    .o_gnt   (w_gnt)
  );

  assign w_load = ~r_yv | bus.y_r;
  assign w_gidx = w_gnt[1];
  assign w_take = w_load & (|w_gnt);
  assign w_gdat = w_gidx ? bus.x1 : bus.x0;

  assign bus.x0_r = w_load & w_gnt[0];
  assign bus.x1_r = w_load & w_gnt[1];
  assign bus.y    = r_y;
  assign bus.y_v  = r_yv;
  assign bus.s    = r_s;

  // Next state: take a granted word, or release
  // ownership once both sources go quiet.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_last_n  = r_last;
    w_y_n     = r_y;
    w_yv_n    = r_yv;
    w_s_n     = r_s;
    if (w_take) begin
      w_state_n = own_st(w_gidx);
      w_y_n     = w_gdat;
      w_yv_n    = 1'b1;
      w_s_n     = w_gidx;
      if (r_state == own_st(w_gidx)) begin
        w_cnt_n = sat_inc(r_cnt, cnt_t'(BURST));
      end else begin
        w_cnt_n  = cnt_t'(1);
        w_last_n = w_gidx;
      end
    end else if (w_load) begin
      w_yv_n = 1'b0;
      if (r_state != IDLE) begin
        w_state_n = IDLE;
        w_last_n  = (r_state == OWN1);
      end
    end
  end

  // State and output registers; reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_y     <= '0;
      r_yv    <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_last  <= w_last_n;
      r_y     <= w_y_n;
      r_yv    <= w_yv_n;
      r_s     <= w_s_n;
    end
  end

endmodule

// File: tb/tb_arb_rr_2a1.sv
// tb_arb_rr_2a1: directed vectors, per-cycle compare
// against a behavioural arbitration model.
module tb_arb_rr_2a1;

  localparam int W     = 8;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  arb_rr_2a1_if #(.W(W)) bus ();

  arb_rr_2a1 #(
    .W     (W),
    .BURST (BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: current owner (-1 none), run length,
  // last served source, and the output register.
  int         m_own;
  int         m_run;
  int         m_last;
  logic [7:0] m_y;
  logic       m_yv;
  logic       m_s;

  logic g0r;
  logic g1r;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_own  = -1;
    m_run  = 0;
    m_last = 1;
    m_y    = 8'h00;
    m_yv   = 1'b0;
    m_s    = 1'b0;
  endtask

  function automatic int winner(
    input logic v0,
    input logic v1
  );
`ifdef ARB_FIXPRI_EN
    if (v0) return 0;
    if (v1) return 1;
    return -1;
`else
    if (v0 && v1) begin
      if (m_own < 0) return 1 - m_last;
      if (m_run < BURST) return m_own;
      return 1 - m_own;
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
`endif
  endfunction

  // One clock: drive, check readies, step model,
  // then check the registered outputs.
  task automatic cycle(
    input logic       r,
    input logic       v0,
    input logic [7:0] d0,
    input logic       v1,
    input logic [7:0] d1,
    input logic       yr
  );
    int w;
    bit ld;
    rst      = r;
    bus.x0_v = v0;
    bus.x0   = d0;
    bus.x1_v = v1;
    bus.x1   = d1;
    bus.y_r  = yr;
    #2;
    ld  = !m_yv || yr;
    w   = winner(v0, v1);
    g0r = bus.x0_r;
    g1r = bus.x1_r;
    chk("x0_r", 32'(g0r), 32'(ld && w == 0));
    chk("x1_r", 32'(g1r), 32'(ld && w == 1));
    if (r) begin
      m_reset();
    end else if (ld) begin
      if (w >= 0) begin
        if (w == m_own) begin
          m_run = (m_run + 1 > BURST) ? BURST : m_run + 1;
        end else begin
          m_own  = w;
          m_run  = 1;
          m_last = w;
        end
        m_y  = (w == 1) ? d1 : d0;
        m_yv = 1'b1;
        m_s  = (w == 1);
      end else begin
        if (m_own >= 0) begin
          m_last = m_own;
          m_own  = -1;
        end
        m_yv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("y", 32'(bus.y), 32'(m_y));
    chk("y_v", 32'(bus.y_v), 32'(m_yv));
    chk("s", 32'(bus.s), 32'(m_s));
  endtask

  int bs[12];

  initial begin
`ifdef ARB_FIXPRI_EN
    bs = '{0,0,0,0,0,0,0,0,0,0,0,0};
`else
    bs = '{0,0,0,0,1,1,1,1,0,0,0,0};
`endif
    m_reset();
    rst      = 1'b1;
    bus.x0   = '0;
    bus.x0_v = 1'b0;
    bus.x1   = '0;
    bus.x1_v = 1'b0;
    bus.y_r  = 1'b0;

    cycle(1, 0, 8'h00, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0, 8'h00, 0);
    chk("rst_y", 32'(bus.y), 32'h00);
    chk("rst_yv", 32'(bus.y_v), 32'h0);
    chk("rst_s", 32'(bus.s), 32'h0);

    // Single source 0 word
    cycle(0, 1, 8'hA5, 0, 8'h00, 1);
    chk("first_x1r", 32'(g1r), 32'h0);
    chk("first_x0r", 32'(g0r), 32'h1);
    chk("first_y", 32'(bus.y), 32'hA5);
    chk("first_yv", 32'(bus.y_v), 32'h1);
    chk("first_s", 32'(bus.s), 32'h0);

    // Burst pattern from a fresh reset
    cycle(1, 0, 8'h00, 0, 8'h00, 1);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 8'(8'h10 + i), 1, 8'(8'h20 + i), 1);
      chk("burst_s", 32'(bus.s), 32'(bs[i]));
      chk("burst_y", 32'(bus.y),
          32'(bs[i] ? 8'h20 + i : 8'h10 + i));
      chk("burst_excl", 32'(g0r & g1r), 32'h0);
    end

    // Downstream stall holding 3C
    cycle(0, 1, 8'h3C, 0, 8'h00, 1);
    chk("stall_load", 32'(bus.y), 32'h3C);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 8'h77, 1, 8'h88, 0);
      chk("stall_y", 32'(bus.y), 32'h3C);
      chk("stall_s", 32'(bus.s), 32'h0);
      chk("stall_rdy", 32'({g0r, g1r}), 32'h0);
    end
    cycle(0, 1, 8'h77, 1, 8'h88, 1);
`ifdef ARB_FIXPRI_EN
    chk("rel_y", 32'(bus.y), 32'h77);
    cycle(0, 0, 8'h00, 1, 8'h88, 1);
    chk("rel2_y", 32'(bus.y), 32'h88);
`else
    chk("rel_y", 32'(bus.y), 32'h88);
    chk("rel_s", 32'(bus.s), 32'h1);
    cycle(0, 1, 8'h77, 0, 8'h00, 1);
    chk("rel2_y", 32'(bus.y), 32'h77);
`endif

    // Owner 0 drops mid-burst
    cycle(1, 0, 8'h00, 0, 8'h00, 1);
    cycle(0, 1, 8'h01, 0, 8'h00, 1);
    cycle(0, 1, 8'h02, 1, 8'h99, 0);
    cycle(0, 1, 8'h02, 0, 8'h00, 1);
    chk("mid_run2", 32'(m_run), 32'd2);
    cycle(0, 0, 8'h00, 1, 8'h99, 1);
    chk("mid_s", 32'(bus.s), 32'h1);
    chk("mid_y", 32'(bus.y), 32'h99);
    chk("mid_run1", 32'(m_run), 32'd1);
    cycle(0, 0, 8'h00, 0, 8'h00, 1);
    chk("drop_yv", 32'(bus.y_v), 32'h0);
    chk("drop_last", 32'(m_last), 32'd1);
    cycle(0, 1, 8'h44, 1, 8'h55, 1);
    chk("tie_s", 32'(bus.s), 32'h0);
    chk("tie_y", 32'(bus.y), 32'h44);

    // Reset wins over a same-cycle handshake
    cycle(0, 0, 8'h00, 1, 8'h5A, 1);
    chk("pre_rst_yv", 32'(bus.y_v), 32'h1);
    cycle(1, 0, 8'h00, 1, 8'h6B, 1);
    chk("rst2_yv", 32'(bus.y_v), 32'h0);
    chk("rst2_s", 32'(bus.s), 32'h0);
    chk("rst2_y", 32'(bus.y), 32'h00);
    cycle(0, 1, 8'h11, 1, 8'h22, 1);
    chk("rst2_tie", 32'(bus.y), 32'h11);

`ifdef ARB_FIXPRI_EN
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 8'(i), 1, 8'(8'h80 + i), 1);
      chk("fix_s", 32'(bus.s), 32'h0);
      chk("fix_x1r", 32'(g1r), 32'h0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
